// File: rtl/uram_drain_responder.sv
// Grants a core write access to URAM, captures its writes in a FIFO and drains them as a valid/ready stream.
// Optional macro URAM_DRAIN_DROP_CNT_EN enables the saturating dropped-write counter on o_drop_cnt.
module uram_drain_responder #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 72,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_core_req,
    output logic              o_core_grant,
    input  logic              i_core_locked,
    input  logic              i_uram_en,
    input  logic              i_uram_wr_en,
    input  logic [ADDR_W-1:0] i_uram_addr,
    input  logic [DATA_W-1:0] i_uram_wr_data,
    output logic              o_uram_emptied,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    output logic [15:0]       o_drop_cnt
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ALMOST_LVL = CW'(FIFO_DEPTH - 2);
    localparam logic [CW-1:0] HALF_LVL   = CW'(FIFO_DEPTH / 2);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        HOLD,
        DRAIN
    } state_t;

    state_t state;

    logic [ADDR_W+DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [CW-1:0]            count;
    logic [CW-1:0]            count_nxt;
    logic                     locked_q;
    logic                     strobe;
    logic                     full;
    logic                     push;
    logic                     pop;

    always_comb begin
        strobe    = i_uram_en & i_uram_wr_en;
        full      = (count == FULL_LVL);
        push      = strobe & o_core_grant & ~full;
        pop       = m_valid & m_ready;
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push && pop) begin
            count_nxt = count - 1'b1;
        end
    end

    assign m_valid         = (count != '0);
    assign {m_addr, m_data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_uram_addr, i_uram_wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
        end
    end

    // Transitions look at the post-edge FIFO level so grant drops on the same
    // edge that stores the write reaching the almost-full mark.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            o_core_grant   <= 1'b0;
            o_uram_emptied <= 1'b1;
            locked_q       <= 1'b0;
        end else begin
            if (i_core_locked) begin
                locked_q <= 1'b1;
            end
            o_core_grant   <= 1'b0;
            o_uram_emptied <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_core_req && !i_core_locked && !locked_q && (count_nxt < ALMOST_LVL)) begin
                        state        <= GRANT;
                        o_core_grant <= 1'b1;
                    end else begin
                        o_uram_emptied <= (count_nxt == '0);
                    end
                end
                GRANT: begin
                    if (!i_core_req || i_core_locked) begin
                        state <= DRAIN;
                    end else if (count_nxt >= ALMOST_LVL) begin
                        state <= HOLD;
                    end else begin
                        o_core_grant <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!i_core_req || i_core_locked) begin
                        state <= DRAIN;
                    end else if (count_nxt < HALF_LVL) begin
                        state        <= GRANT;
                        o_core_grant <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (count_nxt == '0) begin
                        state          <= IDLE;
                        o_uram_emptied <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef URAM_DRAIN_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic        drop;

    assign drop = strobe & (~o_core_grant | full);

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign o_drop_cnt = drop_cnt;
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_uram_drain_responder.sv
// Self-checking bench for uram_drain_responder: a vector table plus scripted sequences, stream checked by a scoreboard.
module tb_uram_drain_responder;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 72;
    localparam int unsigned DEPTH = 16;

`ifdef URAM_DRAIN_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          i_core_req;
    logic          o_core_grant;
    logic          i_core_locked;
    logic          i_uram_en;
    logic          i_uram_wr_en;
    logic [AW-1:0] i_uram_addr;
    logic [DW-1:0] i_uram_wr_data;
    logic          o_uram_emptied;
    logic          m_valid;
    logic          m_ready;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [15:0]   o_drop_cnt;

    int total = 0;
    int bad   = 0;
    int exp_drop;
    logic [AW+DW-1:0] sb [$];
    logic [AW+DW-1:0] exp_w;

    typedef struct packed {
        logic          req;
        logic          en;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          rdy;
        logic          acc;
        logic          eg;
        logic          ev;
        logic          ee;
    } vec_t;

    vec_t tbl [12];

    uram_drain_responder #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_core_req(i_core_req),
        .o_core_grant(o_core_grant),
        .i_core_locked(i_core_locked),
        .i_uram_en(i_uram_en),
        .i_uram_wr_en(i_uram_wr_en),
        .i_uram_addr(i_uram_addr),
        .i_uram_wr_data(i_uram_wr_data),
        .o_uram_emptied(o_uram_emptied),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_addr(m_addr),
        .m_data(m_data),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Stream words are consumed on the next rising edge; sample them mid-cycle.
    always @(negedge clk) begin
        if (reset && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow actual=%0h required=no_word", {m_addr, m_data});
            end else begin
                exp_w = sb.pop_front();
                chk("stream_word", {m_addr, m_data}, exp_w);
            end
        end
    end

    function automatic vec_t mk(input logic req, input logic en, input logic wr,
                                input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input logic rdy, input logic acc,
                                input logic eg, input logic ev, input logic ee);
        vec_t v;
        v.req = req; v.en = en; v.wr = wr; v.addr = addr; v.data = data;
        v.rdy = rdy; v.acc = acc; v.eg = eg; v.ev = ev; v.ee = ee;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_acc);
        i_uram_en      = 1'b1;
        i_uram_wr_en   = 1'b1;
        i_uram_addr    = a;
        i_uram_wr_data = d;
        if (expect_acc) sb.push_back({a, d});
    endtask

    task automatic no_wr();
        i_uram_en    = 1'b0;
        i_uram_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        i_core_req    = 1'b0;
        i_core_locked = 1'b0;
        m_ready       = 1'b0;
        no_wr();
        i_uram_addr    = '0;
        i_uram_wr_data = '0;
        repeat (2) step();
        sb.delete();
        exp_drop = 0;
        reset = 1'b1;
    endtask

    task automatic wait_emptied(input string nm, input int lim);
        int n;
        n = 0;
        while (!o_uram_emptied && n < lim) begin
            step();
            n++;
        end
        chk(nm, o_uram_emptied, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        do_reset();
        chk("rst_grant", o_core_grant, 1'b0);
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_emptied", o_uram_emptied, 1'b1);
        chk("rst_drop", o_drop_cnt, 16'd0);

        // Basic write/drain, write-qualifier gating and drops while not granted
        tbl[0]  = mk(1, 0, 0, 12'd0,   72'h0,  1, 0, 1, 0, 0);
        tbl[1]  = mk(1, 1, 1, 12'd0,   72'hA0, 1, 1, 1, 1, 0);
        tbl[2]  = mk(1, 1, 0, 12'hFFF, 72'hEE, 1, 0, 1, 0, 0);
        tbl[3]  = mk(1, 1, 1, 12'd1,   72'hA1, 1, 1, 1, 1, 0);
        tbl[4]  = mk(1, 1, 1, 12'd2,   72'hA2, 1, 1, 1, 1, 0);
        tbl[5]  = mk(1, 1, 1, 12'd3,   72'hA3, 1, 1, 1, 1, 0);
        tbl[6]  = mk(0, 0, 0, 12'd0,   72'h0,  1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 12'd0,   72'h0,  1, 0, 0, 0, 1);
        tbl[8]  = mk(0, 0, 0, 12'd0,   72'h0,  1, 0, 0, 0, 1);
        tbl[9]  = mk(0, 1, 1, 12'd5,   72'h55, 1, 0, 0, 0, 1);
        tbl[10] = mk(0, 1, 1, 12'd6,   72'h66, 1, 0, 0, 0, 1);
        tbl[11] = mk(0, 1, 1, 12'd7,   72'h77, 1, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            i_core_req     = tbl[i].req;
            i_uram_en      = tbl[i].en;
            i_uram_wr_en   = tbl[i].wr;
            i_uram_addr    = tbl[i].addr;
            i_uram_wr_data = tbl[i].data;
            m_ready        = tbl[i].rdy;
            if (tbl[i].acc) sb.push_back({tbl[i].addr, tbl[i].data});
            if (DROP_EN && tbl[i].en && tbl[i].wr && !tbl[i].acc) exp_drop++;
            step();
            chk($sformatf("vec%0d_grant", i), o_core_grant, tbl[i].eg);
            chk($sformatf("vec%0d_valid", i), m_valid, tbl[i].ev);
            chk($sformatf("vec%0d_emptied", i), o_uram_emptied, tbl[i].ee);
            chk($sformatf("vec%0d_drop", i), o_drop_cnt, exp_drop[15:0]);
        end
        no_wr();
        chk("vec_sb_left", sb.size(), 0);

        // Almost-full hold, then grant returns once the level falls below half
        do_reset();
        i_core_req = 1'b1;
        step();
        chk("hold_grant_up", o_core_grant, 1'b1);
        for (int i = 1; i <= 14; i++) begin
            drive_wr(AW'(12'h100 + i), DW'(i), 1'b1);
            step();
            chk($sformatf("hold_grant_%0d", i), o_core_grant, (i < 14));
        end
        no_wr();
        chk("hold_valid", m_valid, 1'b1);
        m_ready = 1'b1;
        n = 0;
        while (!o_core_grant && n < 30) begin
            step();
            n++;
        end
        chk("hold_regrant_cycles", n, 7);
        i_core_req = 1'b0;
        wait_emptied("hold_emptied", 30);
        chk("hold_sb_left", sb.size(), 0);
        chk("hold_drop", o_drop_cnt, 16'd0);

        // Steady level of 5 with simultaneous push/pop across pointer wrap
        do_reset();
        i_core_req = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            drive_wr(AW'(12'h200 + i), {8'h5A, 64'(i)}, 1'b1);
            step();
        end
        m_ready = 1'b1;
        for (int i = 5; i < 25; i++) begin
            drive_wr(AW'(12'h200 + i), {8'h5A, 64'(i)}, 1'b1);
            step();
            chk($sformatf("pp_grant_%0d", i), o_core_grant, 1'b1);
        end
        no_wr();
        n = 0;
        while (m_valid && n < 40) begin
            step();
            n++;
        end
        chk("pp_level", n, 5);
        i_core_req = 1'b0;
        wait_emptied("pp_emptied", 20);
        chk("pp_sb_left", sb.size(), 0);

        // Reset with entries queued discards them
        do_reset();
        i_core_req = 1'b1;
        drive_wr(12'h3FF, 72'hDEAD, 1'b0);
        step();
        for (int i = 0; i < 6; i++) begin
            drive_wr(AW'(12'h300 + i), DW'(72'hC0 + i), 1'b1);
            step();
        end
        no_wr();
        chk("mrst_pre_valid", m_valid, 1'b1);
        chk("mrst_pre_drop", o_drop_cnt, DROP_EN ? 16'd1 : 16'd0);
        reset = 1'b0;
        i_core_req = 1'b0;
        step();
        sb.delete();
        chk("mrst_valid", m_valid, 1'b0);
        chk("mrst_grant", o_core_grant, 1'b0);
        chk("mrst_drop", o_drop_cnt, 16'd0);
        chk("mrst_emptied", o_uram_emptied, 1'b1);
        reset = 1'b1;
        step();
        chk("mrst_emptied2", o_uram_emptied, 1'b1);
        chk("mrst_valid2", m_valid, 1'b0);

        // Lock during grant: drain to idle and refuse further grants
        do_reset();
        i_core_req = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            drive_wr(AW'(12'h400 + i), DW'(72'hB0 + i), 1'b1);
            step();
        end
        no_wr();
        i_core_locked = 1'b1;
        step();
        chk("lock_grant", o_core_grant, 1'b0);
        chk("lock_valid", m_valid, 1'b1);
        i_core_locked = 1'b0;
        m_ready = 1'b1;
        wait_emptied("lock_emptied", 20);
        chk("lock_sb_left", sb.size(), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("lock_nogrant_%0d", i), o_core_grant, 1'b0);
        end
        chk("lock_emptied_hold", o_uram_emptied, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
